// File: rtl/paddsb_pkg.sv
// Shared types and helpers for the sub-word saturating add/sub unit.
// Lane bounds are computed here so the lane and pipeline agree on them.
package paddsb_pkg;

  typedef struct packed {
    logic sub;
    logic signed_op;
    logic sat;
  } op_mode_t;

  typedef enum logic [1:0] {
    OVF_NONE,
    OVF_POS,
    OVF_NEG
  } ovf_dir_t;

  // Returned right-aligned in 32 bits; callers size-cast to the lane width.
  function automatic logic [31:0] sat_bound(
    input int unsigned w,
    input logic        signed_op,
    input ovf_dir_t    dir
  );
    logic [31:0] ones;
    logic [31:0] smax;
    ones = 32'hFFFF_FFFF >> (32 - w);
    smax = ones >> 1;
    if (dir == OVF_POS)
      return signed_op ? smax : ones;
    if (dir == OVF_NEG)
      return signed_op ? (ones & ~smax) : 32'd0;
    return 32'd0;
  endfunction

endpackage

// File: rtl/paddsb_lane.sv
// One lane: raw LANE_W+1 bit sum/difference, overflow flag and the
// side of the representable range on which the true result lies.
module paddsb_lane
  import paddsb_pkg::*;
#(
  parameter int LANE_W = 4
) (
  input  logic [LANE_W-1:0] a,
  input  logic [LANE_W-1:0] b,
  input  logic              sub,
  input  logic              signed_op,
  output logic [LANE_W-1:0] sum,
  output logic              ovfl,
  output ovf_dir_t          dir
);

  logic [LANE_W:0] ea;
  logic [LANE_W:0] eb;
  logic [LANE_W:0] r;

  always_comb begin
    ea   = {signed_op & a[LANE_W-1], a};
    eb   = {signed_op & b[LANE_W-1], b};
    r    = sub ? (ea - eb) : (ea + eb);
    sum  = r[LANE_W-1:0];
    ovfl = signed_op ? (r[LANE_W] ^ r[LANE_W-1])
                     : r[LANE_W];
    dir  = OVF_NONE;
    // Signed: extra bit is the true sign. Unsigned: carry vs borrow.
    if (ovfl) begin
      if (signed_op)
        dir = r[LANE_W] ? OVF_NEG : OVF_POS;
      else
        dir = sub ? OVF_NEG : OVF_POS;
    end
  end

endmodule

// File: rtl/paddsb_simd_pipe.sv
// Two-stage valid/ready SIMD saturating add/sub with per-lane
// overflow flags and a sticky saturation status register.
module paddsb_simd_pipe
  import paddsb_pkg::*;
#(
  parameter int LANE_W = 4,
  parameter int LANES  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANE_W*LANES-1:0]  in_a,
  input  logic [LANE_W*LANES-1:0]  in_b,
  input  logic                     in_sub,
  input  logic                     in_signed,
  input  logic                     in_sat,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANE_W*LANES-1:0]  out_sum,
  output logic [LANES-1:0]         out_ovfl,
  output logic                     out_ovfl_any,
  output logic [LANES-1:0]         sat_sticky,
  input  logic                     sticky_clr
);

  localparam int DATA_W = LANE_W * LANES;

  op_mode_t          in_mode;
  logic [DATA_W-1:0] lane_sum;
  logic [LANES-1:0]  lane_ovfl;
  ovf_dir_t          lane_dir [LANES];

  logic              s1_valid;
  logic [DATA_W-1:0] s1_raw;
  logic [LANES-1:0]  s1_ovfl;
  ovf_dir_t          s1_dir [LANES];
  logic              s1_signed;
  logic              s1_sat;
  logic [DATA_W-1:0] s2_sum;

  logic s2_adv;
  logic s1_adv;

  assign in_mode  = '{sub: in_sub, signed_op: in_signed, sat: in_sat};
  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    paddsb_lane #(.LANE_W(LANE_W)) u_lane (
      .a         (in_a[i*LANE_W +: LANE_W]),
      .b         (in_b[i*LANE_W +: LANE_W]),
      .sub       (in_mode.sub),
      .signed_op (in_mode.signed_op),
      .sum       (lane_sum[i*LANE_W +: LANE_W]),
      .ovfl      (lane_ovfl[i]),
      .dir       (lane_dir[i])
    );

    assign s2_sum[i*LANE_W +: LANE_W] =
      (s1_sat && s1_dir[i] != OVF_NONE)
        ? LANE_W'(sat_bound(LANE_W, s1_signed, s1_dir[i]))
        : s1_raw[i*LANE_W +: LANE_W];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_raw    <= '0;
      s1_ovfl   <= '0;
      s1_signed <= 1'b0;
      s1_sat    <= 1'b0;
      for (int i = 0; i < LANES; i++)
        s1_dir[i] <= OVF_NONE;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_raw    <= lane_sum;
        s1_ovfl   <= lane_ovfl;
        s1_signed <= in_mode.signed_op;
        s1_sat    <= in_mode.sat;
        for (int i = 0; i < LANES; i++)
          s1_dir[i] <= lane_dir[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_sum      <= '0;
      out_ovfl     <= '0;
      out_ovfl_any <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_sum      <= s2_sum;
        out_ovfl     <= s1_ovfl;
        out_ovfl_any <= |s1_ovfl;
      end
    end
  end

  // A set from a completing transfer overrides a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      sat_sticky <= '0;
    else
      sat_sticky <= ({LANES{out_valid && out_ready}} & out_ovfl)
                  | (sticky_clr ? '0 : sat_sticky);
  end

endmodule

// File: tb/tb_paddsb_simd_pipe.sv
// Directed + random scoreboard bench for paddsb_simd_pipe.
// A second instance covers the 8-bit, 2-lane configuration.
module tb_paddsb_simd_pipe;

  typedef struct {
    logic [15:0] sum;
    logic [3:0]  ovfl;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [15:0] in_a, in_b;
  logic        in_sub, in_signed, in_sat;
  logic        out_valid, out_ready;
  logic [15:0] out_sum;
  logic [3:0]  out_ovfl;
  logic        out_ovfl_any;
  logic [3:0]  sat_sticky;
  logic        sticky_clr;

  logic        in_valid8, in_ready8;
  logic [15:0] in_a8, in_b8;
  logic        out_valid8;
  logic [15:0] out_sum8;
  logic [1:0]  out_ovfl8, sat_sticky8;
  logic        out_ovfl_any8;

  int   vectors = 0;
  int   miscompares = 0;
  int   xfers = 0;
  bit   rnd_on = 1'b0;
  exp_t q[$];

  always #5 clk = ~clk;

  paddsb_simd_pipe dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b),
    .in_sub(in_sub), .in_signed(in_signed), .in_sat(in_sat),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_ovfl(out_ovfl),
    .out_ovfl_any(out_ovfl_any),
    .sat_sticky(sat_sticky), .sticky_clr(sticky_clr)
  );

  paddsb_simd_pipe #(.LANE_W(8), .LANES(2)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid8), .in_ready(in_ready8),
    .in_a(in_a8), .in_b(in_b8),
    .in_sub(1'b0), .in_signed(1'b1), .in_sat(1'b1),
    .out_valid(out_valid8), .out_ready(1'b1),
    .out_sum(out_sum8), .out_ovfl(out_ovfl8),
    .out_ovfl_any(out_ovfl_any8),
    .sat_sticky(sat_sticky8), .sticky_clr(1'b0)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [15:0] a,
                                 input logic [15:0] b,
                                 input logic sub,
                                 input logic sgn,
                                 input logic sat);
    exp_t e;
    int x, y, r, lo, hi;
    e.sum  = '0;
    e.ovfl = '0;
    for (int i = 0; i < 4; i++) begin
      x = int'(a[i*4 +: 4]);
      y = int'(b[i*4 +: 4]);
      if (sgn && x > 7) x -= 16;
      if (sgn && y > 7) y -= 16;
      r  = sub ? x - y : x + y;
      lo = sgn ? -8 : 0;
      hi = sgn ? 7 : 15;
      if (r < lo || r > hi) begin
        e.ovfl[i] = 1'b1;
        if (sat) r = (r > hi) ? hi : lo;
      end
      e.sum[i*4 +: 4] = 4'(r);
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      exp_t e;
      xfers++;
      if (q.size() == 0) begin
        chk("unexpected_out", {16'h0, out_sum}, 32'hFFFF_FFFF);
      end else begin
        e = q.pop_front();
        chk("out_sum", {16'h0, out_sum}, {16'h0, e.sum});
        chk("out_ovfl", {28'h0, out_ovfl}, {28'h0, e.ovfl});
        chk("out_ovfl_any", {31'h0, out_ovfl_any},
            {31'h0, |e.ovfl});
      end
    end
  end

  task automatic issue(input logic [15:0] a, input logic [15:0] b,
                       input logic sub, input logic sgn,
                       input logic sat,
                       input logic [15:0] es, input logic [3:0] eo);
    int   n;
    exp_t e;
    in_a = a; in_b = b;
    in_sub = sub; in_signed = sgn; in_sat = sat;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      @(negedge clk);
      n++;
    end
    chk("accept", {31'h0, in_ready}, 32'h1);
    e.sum  = es;
    e.ovfl = eo;
    if (in_ready) q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic issue_m(input logic [15:0] a, input logic [15:0] b,
                         input logic sub, input logic sgn,
                         input logic sat);
    exp_t e;
    e = model(a, b, sub, sgn, sat);
    issue(a, b, sub, sgn, sat, e.sum, e.ovfl);
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (q.size() != 0 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    chk(tag, q.size(), 0);
  endtask

  initial begin
    int n0;
    exp_t e;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
    in_sub = 1'b0; in_signed = 1'b0; in_sat = 1'b0;
    out_ready = 1'b1; sticky_clr = 1'b0;
    in_valid8 = 1'b0; in_a8 = '0; in_b8 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_out_sum", {16'h0, out_sum}, 32'h0);
    chk("rst_out_ovfl", {28'h0, out_ovfl}, 32'h0);
    chk("rst_ovfl_any", {31'h0, out_ovfl_any}, 32'h0);
    chk("rst_sticky", {28'h0, sat_sticky}, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    issue(16'h7381, 16'h1281, 1'b0, 1'b1, 1'b1, 16'h7582, 4'b1010);
    issue(16'h8075, 16'h1092, 1'b1, 1'b1, 1'b1, 16'h8073, 4'b1010);
    issue(16'hF123, 16'h1111, 1'b0, 1'b0, 1'b1, 16'hF234, 4'b1000);
    issue(16'h0123, 16'h1111, 1'b1, 1'b0, 1'b1, 16'h0012, 4'b1000);
    wait_drain("drain_directed");
    chk("sticky_after_sat", {28'h0, sat_sticky}, 32'hA);
    sticky_clr = 1'b1;
    @(posedge clk); #1;
    sticky_clr = 1'b0;
    chk("sticky_clr", {28'h0, sat_sticky}, 32'h0);
    issue(16'h7000, 16'h1000, 1'b0, 1'b1, 1'b0, 16'h8000, 4'b1000);
    wait_drain("drain_wrap");
    chk("sticky_wrap", {28'h0, sat_sticky}, 32'h8);

    // Backpressure: two ops fill the pipe, the third must wait.
    out_ready = 1'b0;
    issue(16'h000F, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h000F, 4'b0001);
    issue(16'h1234, 16'h1111, 1'b0, 1'b1, 1'b1, 16'h2345, 4'b0000);
    in_a = 16'h0000; in_b = 16'h0001;
    in_sub = 1'b1; in_signed = 1'b0; in_sat = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    chk("bp_in_ready_low", {31'h0, in_ready}, 32'h0);
    chk("bp_out_valid", {31'h0, out_valid}, 32'h1);
    chk("bp_out_sum", {16'h0, out_sum}, 32'h000F);
    @(posedge clk); #1;
    chk("bp_stall_sum", {16'h0, out_sum}, 32'h000F);
    chk("bp_stall_ovfl", {28'h0, out_ovfl}, 32'h1);
    n0 = xfers;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", {31'h0, in_ready}, 32'h1);
    e.sum = 16'h000F; e.ovfl = 4'b0001;
    q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("bp_consecutive", xfers - n0, 3);
    chk("sticky_accum", {28'h0, sat_sticky}, 32'h9);

    // Clear and overflowing transfer in the same cycle.
    out_ready = 1'b0;
    issue(16'h7000, 16'h1000, 1'b0, 1'b1, 1'b1, 16'h7000, 4'b1000);
    @(posedge clk); #1;
    chk("sw_out_valid", {31'h0, out_valid}, 32'h1);
    out_ready = 1'b1;
    sticky_clr = 1'b1;
    @(posedge clk); #1;
    sticky_clr = 1'b0;
    chk("sticky_set_wins", {28'h0, sat_sticky}, 32'h8);

    // Reset with two ops in flight.
    out_ready = 1'b0;
    issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, 16'hFFFF, 4'b0001);
    issue(16'h0000, 16'h0001, 1'b1, 1'b0, 1'b1, 16'h0000, 4'b0001);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", {31'h0, out_valid}, 32'h0);
    chk("mid_rst_sticky", {28'h0, sat_sticky}, 32'h0);
    chk("mid_rst_sum", {16'h0, out_sum}, 32'h0);
    chk("mid_rst_in_ready", {31'h0, in_ready}, 32'h1);
    q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    issue(16'h1234, 16'h1111, 1'b0, 1'b1, 1'b1, 16'h2345, 4'b0000);
    @(negedge clk);
    chk("lat_n1", {31'h0, out_valid}, 32'h0);
    @(posedge clk); #1;
    chk("lat_n2", {31'h0, out_valid}, 32'h1);
    wait_drain("drain_lat");

    // Random stream with random downstream readiness.
    rnd_on = 1'b1;
    fork
      begin
        while (rnd_on) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
      begin
        for (int k = 0; k < 100; k++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
          end
          issue_m(16'($urandom), 16'($urandom),
                  1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
        end
        rnd_on = 1'b0;
      end
    join
    out_ready = 1'b1;
    wait_drain("drain_random");

    // 8-bit, 2-lane configuration.
    in_a8 = 16'h7F80; in_b8 = 16'h01FF;
    in_valid8 = 1'b1;
    @(negedge clk);
    chk("w8_in_ready", {31'h0, in_ready8}, 32'h1);
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    @(negedge clk);
    chk("w8_lat_n1", {31'h0, out_valid8}, 32'h0);
    @(posedge clk); #1;
    chk("w8_out_valid", {31'h0, out_valid8}, 32'h1);
    chk("w8_out_sum", {16'h0, out_sum8}, 32'h7F80);
    chk("w8_out_ovfl", {30'h0, out_ovfl8}, 32'h3);
    chk("w8_ovfl_any", {31'h0, out_ovfl_any8}, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
